// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the two-requester UART port arbiter.
// Requester 0 is the misc execution element, requester 1 the loader/debug monitor.
package uart_arb_pkg;

  localparam int NUM_REQ = 2;

  // Requester identifier: one bit is enough for two requesters.
  typedef logic [0:0] req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // Per-channel handshake sequencing.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Round-robin pick: on a tie the requester that did not own the channel
  // last wins; otherwise the single eligible requester is chosen.
  function automatic req_id_t rr_pick(input logic [NUM_REQ-1:0] eligible,
                                      input req_id_t last_owner);
    if (&eligible) begin
      return req_id_t'(~last_owner);
    end else if (eligible[1]) begin
      return REQ1;
    end else begin
      return REQ0;
    end
  endfunction

endpackage

// File: rtl/uart_port_arbiter_if.sv
// Bundle of requester-side and UART-side signals around the port arbiter.
// slave modport: the arbiter's view; master modport: the surrounding system.
interface uart_port_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int STAT_WIDTH = 16
);

  // Requester side
  logic [NUM_REQ-1:0]                 req_tx_valid;
  logic [NUM_REQ-1:0][7:0]            req_tx_data;
  logic [NUM_REQ-1:0]                 req_tx_ready;
  logic [NUM_REQ-1:0]                 req_rx_valid;
  logic [7:0]                         req_rx_data;
  logic [NUM_REQ-1:0]                 req_rx_ready;
  logic                               lock1;

  // UART wrapper side
  logic                               uart_tx_valid;
  logic [7:0]                         uart_tx_data;
  logic                               uart_tx_ready;
  logic                               uart_rx_valid;
  logic [7:0]                         uart_rx_data;
  logic                               uart_rx_ready;

  // Status
  logic                               tx_owner;
  logic                               rx_owner;
  logic [NUM_REQ-1:0][STAT_WIDTH-1:0] stat_tx_count;
  logic [NUM_REQ-1:0][STAT_WIDTH-1:0] stat_rx_count;

  modport slave (
    input  req_tx_valid, req_tx_data, req_rx_valid, lock1,
    input  uart_tx_ready, uart_rx_data, uart_rx_ready,
    output req_tx_ready, req_rx_data, req_rx_ready,
    output uart_tx_valid, uart_tx_data, uart_rx_valid,
    output tx_owner, rx_owner, stat_tx_count, stat_rx_count
  );

  modport master (
    output req_tx_valid, req_tx_data, req_rx_valid, lock1,
    output uart_tx_ready, uart_rx_data, uart_rx_ready,
    input  req_tx_ready, req_rx_data, req_rx_ready,
    input  uart_tx_valid, uart_tx_data, uart_rx_valid,
    input  tx_owner, rx_owner, stat_tx_count, stat_rx_count
  );

endinterface

// File: rtl/uart_arb_channel.sv
// One arbitrated UART direction: IDLE -> ISSUE -> ACK -> RELEASE FSM with
// round-robin grant, requester-1 lock and optional per-requester counters.
// IS_RX=0: byte is taken from the granted requester when the grant is made.
// IS_RX=1: byte is taken from the UART when it signals ready.
// Optional feature macro: UART_ARB_STATS_EN (live transfer counters).
module uart_arb_channel
  import uart_arb_pkg::*;
#(
  parameter bit IS_RX      = 1'b0,
  parameter int STAT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][7:0]            src_data,
  input  logic                               lock1,
  input  logic                               uart_ready,
  output logic                               uart_valid,
  output logic [7:0]                         data_q,
  output logic [NUM_REQ-1:0]                 req_ready,
  output req_id_t                            owner,
  output logic [NUM_REQ-1:0][STAT_WIDTH-1:0] stat_count
);

  arb_state_t         state;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_any;
  req_id_t            grant_id;

  // Decide who may be granted this cycle; only consulted in IDLE, so the
  // previous owner's lingering valid during RELEASE is never seen.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    eligible  = req_valid;
    if (lock1) begin
      eligible[0] = 1'b0;
    end
    grant_any = |eligible;
    grant_id  = rr_pick(eligible, owner);
  end

  // Channel FSM with registered UART valid, data, ready pulses and owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      uart_valid <= 1'b0;
      data_q     <= '0;
      req_ready  <= '0;
      owner      <= REQ1;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      req_ready <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_id;
            uart_valid <= 1'b1;
            if (!IS_RX) begin
              data_q <= src_data[grant_id];
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          // Requester dropping valid here does not abort the transfer.
          if (uart_ready) begin
            uart_valid       <= 1'b0;
            req_ready[owner] <= 1'b1;
            if (IS_RX) begin
              data_q <= src_data[owner];
            end
            state <= ACK;
          end
        end
        ACK: begin
          state <= RELEASE;
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_ARB_STATS_EN
  // Count completed transfers per requester; the count moves with the
  // ready pulse and wraps modulo 2^STAT_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_count <= '0;
    end else if (state == ISSUE && uart_ready) begin
      stat_count[owner] <= stat_count[owner] + STAT_WIDTH'(1);
    end
  end
`else
  // Counters not built: report zero.
  assign stat_count = '0;
`endif

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares the UART TX and RX channels between requester 0 (IN/OUT execution
// element) and requester 1 (loader/debug monitor). Each direction runs its
// own arbitration channel; the two never interact.
// Optional feature macro: UART_ARB_STATS_EN (per-requester transfer counters).
module uart_port_arbiter
  import uart_arb_pkg::*;
#(
  parameter int STAT_WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  uart_port_arbiter_if.slave bus
);

  // The RX byte comes from the UART regardless of owner; present it on
  // every requester slot so the channel can capture by owner index.
  logic [NUM_REQ-1:0][7:0] rx_src;

  assign rx_src = {NUM_REQ{bus.uart_rx_data}};

  uart_arb_channel #(
    .IS_RX      (1'b0),
    .STAT_WIDTH (STAT_WIDTH)
  ) u_tx_chan (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (bus.req_tx_valid),
    .src_data   (bus.req_tx_data),
    .lock1      (bus.lock1),
    .uart_ready (bus.uart_tx_ready),
    .uart_valid (bus.uart_tx_valid),
    .data_q     (bus.uart_tx_data),
    .req_ready  (bus.req_tx_ready),
    .owner      (bus.tx_owner),
    .stat_count (bus.stat_tx_count)
  );

  uart_arb_channel #(
    .IS_RX      (1'b1),
    .STAT_WIDTH (STAT_WIDTH)
  ) u_rx_chan (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (bus.req_rx_valid),
    .src_data   (rx_src),
    .lock1      (bus.lock1),
    .uart_ready (bus.uart_rx_ready),
    .uart_valid (bus.uart_rx_valid),
    .data_q     (bus.req_rx_data),
    .req_ready  (bus.req_rx_ready),
    .owner      (bus.rx_owner),
    .stat_count (bus.stat_rx_count)
  );

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed self-checking bench for uart_port_arbiter. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge.
module tb_uart_port_arbiter;
  import uart_arb_pkg::*;

  localparam int SW = 16;
`ifdef UART_ARB_STATS_EN
  localparam int STAT_ON = 1;
`else
  localparam int STAT_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_port_arbiter_if #(.STAT_WIDTH(SW)) bus();

  uart_port_arbiter #(.STAT_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_tx_valid  = '0;
    bus.req_tx_data   = '0;
    bus.req_rx_valid  = '0;
    bus.lock1         = 1'b0;
    bus.uart_tx_ready = 1'b0;
    bus.uart_rx_data  = '0;
    bus.uart_rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_tests++; if (bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_uart_tx_valid: got %b want 0", bus.uart_tx_valid); end
    n_tests++; if (bus.uart_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_uart_rx_valid: got %b want 0", bus.uart_rx_valid); end
    n_tests++; if (bus.req_tx_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_tx_ready: got %b want 00", bus.req_tx_ready); end
    n_tests++; if (bus.req_rx_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_rx_ready: got %b want 00", bus.req_rx_ready); end
    n_tests++; if (bus.uart_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_uart_tx_data: got %h want 00", bus.uart_tx_data); end
    n_tests++; if (bus.req_rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_req_rx_data: got %h want 00", bus.req_rx_data); end
    n_tests++; if (bus.tx_owner !== 1'b1) begin n_fail++; $display("FAIL reset_tx_owner: got %b want 1", bus.tx_owner); end
    n_tests++; if (bus.rx_owner !== 1'b1) begin n_fail++; $display("FAIL reset_rx_owner: got %b want 1", bus.rx_owner); end
    n_tests++; if (bus.stat_tx_count !== '0) begin n_fail++; $display("FAIL reset_stat_tx: got %h want 0", bus.stat_tx_count); end
    n_tests++; if (bus.stat_rx_count !== '0) begin n_fail++; $display("FAIL reset_stat_rx: got %h want 0", bus.stat_rx_count); end
  endtask

  // Req 0 sends 0x41; UART answers 3 cycles after valid rises.
  task automatic test_single_tx();
    bus.req_tx_valid   = 2'b01;
    bus.req_tx_data[0] = 8'h41;
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_rise: got %b want 1", bus.uart_tx_valid); end
    n_tests++; if (bus.uart_tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", bus.uart_tx_data); end
    n_tests++; if (bus.tx_owner !== 1'b0) begin n_fail++; $display("FAIL single_owner: got %b want 0", bus.tx_owner); end
    bus.req_tx_data[0] = 8'hEE;
    tick();
    n_tests++; if (bus.uart_tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data_stable: got %h want 41", bus.uart_tx_data); end
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_hold: got %b want 1", bus.uart_tx_valid); end
    n_tests++; if (bus.req_tx_ready !== 2'b00) begin n_fail++; $display("FAIL single_no_early_ready: got %b want 00", bus.req_tx_ready); end
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;
    n_tests++; if (bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", bus.uart_tx_valid); end
    n_tests++; if (bus.req_tx_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready_pulse: got %b want 01", bus.req_tx_ready); end
    n_tests++; if (bus.stat_tx_count[0] !== SW'(STAT_ON)) begin n_fail++; $display("FAIL single_stat: got %0d want %0d", bus.stat_tx_count[0], STAT_ON); end
    tick();
    bus.req_tx_valid = 2'b00;
    n_tests++; if (bus.req_tx_ready !== 2'b00) begin n_fail++; $display("FAIL single_ready_one_cycle: got %b want 00", bus.req_tx_ready); end
    tick();
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: got %b want 0", bus.uart_tx_valid); end
  endtask

  // Req 0 holds valid through ACK and RELEASE; no second transfer may start.
  task automatic test_no_duplicate();
    bus.req_tx_valid   = 2'b01;
    bus.req_tx_data[0] = 8'h5C;
    tick();
    n_tests++; if (bus.uart_tx_data !== 8'h5C) begin n_fail++; $display("FAIL nodup_data: got %h want 5c", bus.uart_tx_data); end
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;
    n_tests++; if (bus.req_tx_ready !== 2'b01) begin n_fail++; $display("FAIL nodup_ready: got %b want 01", bus.req_tx_ready); end
    tick();
    tick();
    bus.req_tx_valid = 2'b00;
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL nodup_no_reissue: got %b want 0", bus.uart_tx_valid); end
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b0 || bus.req_tx_ready !== 2'b00) begin n_fail++; $display("FAIL nodup_quiet: got valid %b ready %b want 0 00", bus.uart_tx_valid, bus.req_tx_ready); end
  endtask

  // Both request after reset: 0x11 (req 0) first, then 0x22 (req 1), 4 cycles apart.
  task automatic test_tie_tx();
    do_reset();
    bus.req_tx_valid   = 2'b11;
    bus.req_tx_data[0] = 8'h11;
    bus.req_tx_data[1] = 8'h22;
    tick();
    n_tests++; if (bus.uart_tx_data !== 8'h11 || bus.tx_owner !== 1'b0) begin n_fail++; $display("FAIL tie_first: got data %h owner %b want 11 0", bus.uart_tx_data, bus.tx_owner); end
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;
    n_tests++; if (bus.req_tx_ready !== 2'b01) begin n_fail++; $display("FAIL tie_first_ready: got %b want 01", bus.req_tx_ready); end
    tick();
    bus.req_tx_valid = 2'b10;
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tie_spacing: got %b want 0", bus.uart_tx_valid); end
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL tie_second_valid: got %b want 1", bus.uart_tx_valid); end
    n_tests++; if (bus.uart_tx_data !== 8'h22 || bus.tx_owner !== 1'b1) begin n_fail++; $display("FAIL tie_second: got data %h owner %b want 22 1", bus.uart_tx_data, bus.tx_owner); end
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;
    n_tests++; if (bus.req_tx_ready !== 2'b10) begin n_fail++; $display("FAIL tie_second_ready: got %b want 10", bus.req_tx_ready); end
    n_tests++; if (bus.stat_tx_count[0] !== SW'(STAT_ON) || bus.stat_tx_count[1] !== SW'(STAT_ON)) begin n_fail++; $display("FAIL tie_stat: got %0d/%0d want %0d/%0d", bus.stat_tx_count[0], bus.stat_tx_count[1], STAT_ON, STAT_ON); end
    tick();
    bus.req_tx_valid = 2'b00;
    tick();
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL tie_idle_after: got %b want 0", bus.uart_tx_valid); end
  endtask

  // lock1 with both RX requesting: 0x5A and 0xA5 go to req 1, then req 0 after unlock.
  task automatic test_lock_rx();
    bus.lock1        = 1'b1;
    bus.req_rx_valid = 2'b11;
    tick();
    n_tests++; if (bus.uart_rx_valid !== 1'b1 || bus.rx_owner !== 1'b1) begin n_fail++; $display("FAIL lock_first_grant: got valid %b owner %b want 1 1", bus.uart_rx_valid, bus.rx_owner); end
    bus.uart_rx_data  = 8'h5A;
    bus.uart_rx_ready = 1'b1;
    tick();
    bus.uart_rx_ready = 1'b0;
    bus.uart_rx_data  = 8'h00;
    n_tests++; if (bus.req_rx_ready !== 2'b10 || bus.req_rx_data !== 8'h5A) begin n_fail++; $display("FAIL lock_first_byte: got ready %b data %h want 10 5a", bus.req_rx_ready, bus.req_rx_data); end
    tick();
    n_tests++; if (bus.req_rx_data !== 8'h5A) begin n_fail++; $display("FAIL lock_data_hold: got %h want 5a", bus.req_rx_data); end
    tick();
    n_tests++; if (bus.uart_rx_valid !== 1'b0) begin n_fail++; $display("FAIL lock_spacing: got %b want 0", bus.uart_rx_valid); end
    tick();
    n_tests++; if (bus.uart_rx_valid !== 1'b1 || bus.rx_owner !== 1'b1) begin n_fail++; $display("FAIL lock_second_grant: got valid %b owner %b want 1 1", bus.uart_rx_valid, bus.rx_owner); end
    bus.uart_rx_data  = 8'hA5;
    bus.uart_rx_ready = 1'b1;
    tick();
    bus.uart_rx_ready = 1'b0;
    n_tests++; if (bus.req_rx_ready !== 2'b10 || bus.req_rx_data !== 8'hA5) begin n_fail++; $display("FAIL lock_second_byte: got ready %b data %h want 10 a5", bus.req_rx_ready, bus.req_rx_data); end
    tick();
    bus.req_rx_valid = 2'b01;
    bus.lock1        = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.uart_rx_valid !== 1'b1 || bus.rx_owner !== 1'b0) begin n_fail++; $display("FAIL lock_release_grant: got valid %b owner %b want 1 0", bus.uart_rx_valid, bus.rx_owner); end
    bus.uart_rx_data  = 8'h33;
    bus.uart_rx_ready = 1'b1;
    tick();
    bus.uart_rx_ready = 1'b0;
    n_tests++; if (bus.req_rx_ready !== 2'b01 || bus.req_rx_data !== 8'h33) begin n_fail++; $display("FAIL lock_req0_byte: got ready %b data %h want 01 33", bus.req_rx_ready, bus.req_rx_data); end
    n_tests++; if (bus.stat_rx_count[0] !== SW'(STAT_ON) || bus.stat_rx_count[1] !== SW'(2 * STAT_ON)) begin n_fail++; $display("FAIL lock_stat: got %0d/%0d want %0d/%0d", bus.stat_rx_count[0], bus.stat_rx_count[1], STAT_ON, 2 * STAT_ON); end
    tick();
    bus.req_rx_valid = 2'b00;
    tick();
    tick();
  endtask

  // TX by req 0 and RX by req 1 at once; lock1 raised mid-transfer must not abort TX.
  task automatic test_concurrent();
    bus.req_tx_valid   = 2'b01;
    bus.req_tx_data[0] = 8'h77;
    bus.req_rx_valid   = 2'b10;
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b1 || bus.uart_rx_valid !== 1'b1) begin n_fail++; $display("FAIL conc_both_valid: got tx %b rx %b want 1 1", bus.uart_tx_valid, bus.uart_rx_valid); end
    n_tests++; if (bus.tx_owner !== 1'b0 || bus.rx_owner !== 1'b1) begin n_fail++; $display("FAIL conc_owners: got tx %b rx %b want 0 1", bus.tx_owner, bus.rx_owner); end
    bus.lock1         = 1'b1;
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;
    n_tests++; if (bus.req_tx_ready !== 2'b01 || bus.uart_tx_valid !== 1'b0) begin n_fail++; $display("FAIL conc_tx_done: got ready %b valid %b want 01 0", bus.req_tx_ready, bus.uart_tx_valid); end
    n_tests++; if (bus.uart_rx_valid !== 1'b1 || bus.req_rx_ready !== 2'b00) begin n_fail++; $display("FAIL conc_rx_pending: got valid %b ready %b want 1 00", bus.uart_rx_valid, bus.req_rx_ready); end
    bus.uart_rx_data  = 8'hC3;
    bus.uart_rx_ready = 1'b1;
    tick();
    bus.uart_rx_ready = 1'b0;
    bus.req_tx_valid  = 2'b00;
    n_tests++; if (bus.req_rx_ready !== 2'b10 || bus.req_rx_data !== 8'hC3) begin n_fail++; $display("FAIL conc_rx_done: got ready %b data %h want 10 c3", bus.req_rx_ready, bus.req_rx_data); end
    n_tests++; if (bus.req_tx_ready !== 2'b00) begin n_fail++; $display("FAIL conc_tx_one_pulse: got %b want 00", bus.req_tx_ready); end
    tick();
    bus.req_rx_valid = 2'b00;
    bus.lock1        = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b0 || bus.uart_rx_valid !== 1'b0) begin n_fail++; $display("FAIL conc_idle_after: got tx %b rx %b want 0 0", bus.uart_tx_valid, bus.uart_rx_valid); end
  endtask

  // Req 1 drops valid while in ISSUE; transfer still completes with a ready pulse.
  task automatic test_drop_in_issue();
    bus.req_tx_valid   = 2'b10;
    bus.req_tx_data[1] = 8'h9D;
    tick();
    bus.req_tx_valid = 2'b00;
    n_tests++; if (bus.tx_owner !== 1'b1 || bus.uart_tx_data !== 8'h9D) begin n_fail++; $display("FAIL drop_grant: got owner %b data %h want 1 9d", bus.tx_owner, bus.uart_tx_data); end
    tick();
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b1) begin n_fail++; $display("FAIL drop_no_abort: got %b want 1", bus.uart_tx_valid); end
    bus.uart_tx_ready = 1'b1;
    tick();
    bus.uart_tx_ready = 1'b0;
    n_tests++; if (bus.req_tx_ready !== 2'b10) begin n_fail++; $display("FAIL drop_ready: got %b want 10", bus.req_tx_ready); end
    tick();
    tick();
    tick();
  endtask

  // Reset while both channels are in ISSUE: outputs clear at once, no ready pulse.
  task automatic test_reset_mid();
    bus.req_tx_valid   = 2'b01;
    bus.req_tx_data[0] = 8'h4B;
    bus.req_rx_valid   = 2'b01;
    tick();
    n_tests++; if (bus.uart_tx_valid !== 1'b1 || bus.uart_rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue: got tx %b rx %b want 1 1", bus.uart_tx_valid, bus.uart_rx_valid); end
    reset = 1'b1;
    #1;
    n_tests++; if (bus.uart_tx_valid !== 1'b0 || bus.uart_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_valid: got tx %b rx %b want 0 0", bus.uart_tx_valid, bus.uart_rx_valid); end
    n_tests++; if (bus.uart_tx_data !== 8'h00 || bus.tx_owner !== 1'b1 || bus.rx_owner !== 1'b1) begin n_fail++; $display("FAIL rstmid_async_state: got data %h owners %b%b want 00 11", bus.uart_tx_data, bus.tx_owner, bus.rx_owner); end
    bus.uart_tx_ready = 1'b1;
    bus.uart_rx_ready = 1'b1;
    bus.uart_rx_data  = 8'h99;
    tick();
    n_tests++; if (bus.req_tx_ready !== 2'b00 || bus.req_rx_ready !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_pulse: got tx %b rx %b want 00 00", bus.req_tx_ready, bus.req_rx_ready); end
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.req_tx_ready !== 2'b00 || bus.req_rx_ready !== 2'b00 || bus.req_rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_after: got tx %b rx %b data %h want 00 00 00", bus.req_tx_ready, bus.req_rx_ready, bus.req_rx_data); end
    n_tests++; if (bus.stat_tx_count !== '0 || bus.stat_rx_count !== '0) begin n_fail++; $display("FAIL rstmid_stats: got %h %h want 0 0", bus.stat_tx_count, bus.stat_rx_count); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    tick();
    test_single_tx();
    test_no_duplicate();
    test_tie_tx();
    test_lock_rx();
    test_concurrent();
    test_drop_in_issue();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
